// File: rtl/keycode_event_queue_if.sv
// Event stream from keycode_event_queue to the game-logic consumer.
// The master presents the head event; the slave pops it with ev_ready.
interface keycode_event_queue_if;
   logic [9:0] ev_data;
   logic       ev_valid;
   logic       ev_ready;

   modport master (output ev_data, output ev_valid, input ev_ready);
   modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/keycode_event_queue.sv
// Debounces the SoC keycode PIO and turns accepted level changes into
// press/release/repeat events held in a first-word-fall-through FIFO.
module keycode_event_queue #(
   parameter int STABLE_CYCLES = 16,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000,
   parameter int DEPTH         = 8
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset_n,
   input  logic [7:0]             keycode,
   keycode_event_queue_if.master  ev,
   output logic [$clog2(DEPTH):0] ev_count,
   output logic [7:0]             held_key,
   output logic                   overflow,
   input  logic                   overflow_clr
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = $clog2(STABLE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
   localparam logic [RW-1:0] R_FIRST  = (REPEAT_DELAY > 0) ? RW'(REPEAT_DELAY - 1) : '0;
   localparam logic [RW-1:0] R_NEXT   = RW'(REPEAT_PERIOD - 1);
   localparam logic [AW:0]   FULL_C   = (AW+1)'(DEPTH);

   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_RELEASE = 2'b10;
   localparam logic [1:0] EV_REPEAT  = 2'b11;

   logic [7:0]              cand_q, cand_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [7:0]              held_q, held_d;
   logic                    pend_q, pend_d;
   logic [RW-1:0]           rpt_q, rpt_d;
   logic [DEPTH-1:0][9:0]   mem_q;
   logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]             count_q, count_d;
   logic                    ovf_q, ovf_d;

   logic       commit, push, pop, full, wr_en, drop;
   logic [9:0] push_data;

   assign pop  = (count_q != '0) && ev.ev_ready;
   assign full = (count_q == FULL_C);

   always_comb begin
      cand_d    = keycode;
      cnt_d     = (keycode != cand_q) ? CW'(1)
                : (cnt_q == STABLE_C) ? cnt_q : cnt_q + 1'b1;
      commit    = (cnt_d == STABLE_C) && (keycode != held_q) && !pend_q;
      held_d    = held_q;
      pend_d    = pend_q;
      rpt_d     = rpt_q;
      push      = 1'b0;
      push_data = '0;
      if (commit) begin
         held_d = keycode;
         rpt_d  = R_FIRST;
         push   = 1'b1;
         if (held_q == 8'h00) begin
            push_data = {EV_PRESS, keycode};
         end else begin
            push_data = {EV_RELEASE, held_q};
            // A->B: the press of B goes out on the next edge
            pend_d    = (keycode != 8'h00);
         end
      end else if (pend_q) begin
         push      = 1'b1;
         push_data = {EV_PRESS, held_q};
         pend_d    = 1'b0;
         rpt_d     = R_FIRST;
      end else if (held_q != 8'h00 && REPEAT_DELAY != 0) begin
         if (rpt_q == '0) begin
            push      = 1'b1;
            push_data = {EV_REPEAT, held_q};
            rpt_d     = R_NEXT;
         end else begin
            rpt_d = rpt_q - 1'b1;
         end
      end
   end

   always_comb begin
      wr_en   = push && (!full || pop);
      drop    = push && full && !pop;
      wr_d    = wr_en ? wr_q + 1'b1 : wr_q;
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // a drop wins over a simultaneous clear so no loss goes unreported
      ovf_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cand_q  <= '0;
         cnt_q   <= '0;
         held_q  <= '0;
         pend_q  <= 1'b0;
         rpt_q   <= '0;
         mem_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         held_q  <= held_d;
         pend_q  <= pend_d;
         rpt_q   <= rpt_d;
         if (wr_en) mem_q[wr_q] <= push_data;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ev.ev_valid = (count_q != '0);
   assign ev.ev_data  = (count_q != '0) ? mem_q[rd_q] : '0;
   assign ev_count    = count_q;
   assign held_key    = held_q;
   assign overflow    = ovf_q;
endmodule
